// File: rtl/gtxe2_chnl_tx_oob.sv
// TX-side SATA OOB generator: turns COMINIT/COMWAKE requests into burst/gap line patterns, else passes serial data or idles.
// Optional COMSAS request kind is enabled by defining GTXE2_TX_OOB_COMSAS_EN.
module gtxe2_chnl_tx_oob #(
    parameter int unsigned burst_len    = 240,
    parameter int unsigned wake_gap_len = 240,
    parameter int unsigned init_gap_len = 720,
`ifdef GTXE2_TX_OOB_COMSAS_EN
    parameter int unsigned sas_gap_len  = 2160,
`endif
    parameter int unsigned bursts_num   = 6,
    parameter int unsigned cnt_width    = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic TXCOMINIT,
    input  logic TXCOMWAKE,
`ifdef GTXE2_TX_OOB_COMSAS_EN
    input  logic TXCOMSAS,
`endif
    input  logic TXELECIDLE,
    input  logic ser_p,
    input  logic ser_n,
    output logic TXP,
    output logic TXN,
    output logic TXCOMFINISH,
    output logic oob_active
);

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP, ST_FIN} state_t;
    typedef enum logic [1:0] {KIND_INIT, KIND_WAKE, KIND_SAS} kind_t;

    localparam logic [cnt_width-1:0] burst_last = cnt_width'(burst_len - 1);
    localparam logic [cnt_width-1:0] bursts_end = cnt_width'(bursts_num);

    state_t               state;
    kind_t                kind;
    kind_t                req_kind;
    logic                 req;
    logic                 toggle;
    logic [cnt_width-1:0] len_cnt;
    logic [cnt_width-1:0] burst_cnt;
    logic [cnt_width-1:0] gap_last;

    // Request decode with INIT > WAKE > SAS priority
    always_comb begin
        req      = TXCOMINIT | TXCOMWAKE;
        req_kind = TXCOMINIT ? KIND_INIT : KIND_WAKE;
`ifdef GTXE2_TX_OOB_COMSAS_EN
        req = req | TXCOMSAS;
        if (!TXCOMINIT && !TXCOMWAKE) begin
            req_kind = KIND_SAS;
        end
`endif
    end

    always_comb begin
        case (kind)
            KIND_INIT: gap_last = cnt_width'(init_gap_len - 1);
`ifdef GTXE2_TX_OOB_COMSAS_EN
            KIND_SAS:  gap_last = cnt_width'(sas_gap_len - 1);
`endif
            default:   gap_last = cnt_width'(wake_gap_len - 1);
        endcase
    end

    // State register holds the phase currently on the line; outputs are set for the next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            kind        <= KIND_INIT;
            len_cnt     <= '0;
            burst_cnt   <= '0;
            toggle      <= 1'b1;
            TXP         <= 1'b0;
            TXN         <= 1'b0;
            TXCOMFINISH <= 1'b0;
            oob_active  <= 1'b0;
        end else begin
            TXCOMFINISH <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state      <= ST_BURST;
                        kind       <= req_kind;
                        len_cnt    <= '0;
                        burst_cnt  <= '0;
                        TXP        <= toggle;
                        TXN        <= ~toggle;
                        toggle     <= ~toggle;
                        oob_active <= 1'b1;
                    end else begin
                        TXP <= ~TXELECIDLE & ser_p;
                        TXN <= ~TXELECIDLE & ser_n;
                    end
                end
                ST_BURST: begin
                    if (len_cnt == burst_last) begin
                        state     <= ST_GAP;
                        len_cnt   <= '0;
                        burst_cnt <= burst_cnt + cnt_width'(1);
                        TXP       <= 1'b0;
                        TXN       <= 1'b0;
                    end else begin
                        len_cnt <= len_cnt + cnt_width'(1);
                        TXP     <= toggle;
                        TXN     <= ~toggle;
                        toggle  <= ~toggle;
                    end
                end
                ST_GAP: begin
                    TXP <= 1'b0;
                    TXN <= 1'b0;
                    if (len_cnt == gap_last) begin
                        len_cnt <= '0;
                        if (burst_cnt == bursts_end) begin
                            state       <= ST_FIN;
                            TXCOMFINISH <= 1'b1;
                        end else begin
                            state  <= ST_BURST;
                            TXP    <= 1'b1;
                            TXN    <= 1'b0;
                            toggle <= 1'b0;
                        end
                    end else begin
                        len_cnt <= len_cnt + cnt_width'(1);
                    end
                end
                ST_FIN: begin
                    state      <= ST_IDLE;
                    oob_active <= 1'b0;
                    toggle     <= 1'b1;
                    TXP        <= ~TXELECIDLE & ser_p;
                    TXN        <= ~TXELECIDLE & ser_n;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
